// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, latencies, mode encoding and atan table for the CORDIC array
package cordic_pkg;

  localparam int CORDIC_W = 16;
  localparam int ADD_LAT  = 5;

  // Per-sample operating mode carried alongside the data
  typedef enum logic {
    MODE_ROT = 1'b0,   // steer z toward zero
    MODE_VEC = 1'b1    // steer y toward zero
  } cordic_mode_e;

  // atan(2^-i) in angle units where 16'h8000 represents pi
  function automatic logic [CORDIC_W-1:0] atan_lut(input int i);
    case (i)
      0:       return 16'h2000;
      1:       return 16'h12E4;
      2:       return 16'h09FB;
      3:       return 16'h0511;
      4:       return 16'h028B;
      5:       return 16'h0146;
      6:       return 16'h00A3;
      7:       return 16'h0051;
      8:       return 16'h0029;
      9:       return 16'h0014;
      10:      return 16'h000A;
      11:      return 16'h0005;
      12:      return 16'h0003;
      13:      return 16'h0001;
      14:      return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - 16-bit add/sub slice, 5 register stages, sign=1 computes a1-a2
module adder_pipe
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic [CORDIC_W-1:0] a1,
  input  logic [CORDIC_W-1:0] a2,
  input  logic                sign,
  output logic [CORDIC_W-1:0] sum
);

  localparam int H = CORDIC_W / 2;

  logic [CORDIC_W-1:0] s1_a;
  logic [CORDIC_W-1:0] s1_b;
  logic                s1_cin;
  logic [H:0]          s2_lo;
  logic [H-1:0]        s2_a_hi;
  logic [H-1:0]        s2_b_hi;
  logic [CORDIC_W-1:0] s3_sum;
  logic [CORDIC_W-1:0] s4_sum;
  logic [CORDIC_W-1:0] s5_sum;

  // Stage 1: capture operands; subtraction becomes a1 + ~a2 + 1
  always_ff @(posedge clk) begin
    s1_a   <= a1;
    s1_b   <= sign ? ~a2 : a2;
    s1_cin <= sign;
  end

  // Stage 2: low half sum with its carry out, high halves carried along
  always_ff @(posedge clk) begin
    s2_lo   <= {1'b0, s1_a[H-1:0]} + {1'b0, s1_b[H-1:0]} + {{H{1'b0}}, s1_cin};
    s2_a_hi <= s1_a[CORDIC_W-1:H];
    s2_b_hi <= s1_b[CORDIC_W-1:H];
  end

  // Stage 3: high half sum absorbs the low carry; result wraps modulo 2^16
  always_ff @(posedge clk) begin
    s3_sum <= {s2_a_hi + s2_b_hi + {{(H-1){1'b0}}, s2_lo[H]}, s2_lo[H-1:0]};
  end

  // Stages 4-5: retiming slack so the slice meets timing next to wide routing
  always_ff @(posedge clk) begin
    s4_sum <= s3_sum;
    s5_sum <= s4_sum;
  end

  assign sum = s5_sum;

endmodule

// File: rtl/cordic_delay_line.sv
// rtl/cordic_delay_line.sv - width/depth parameterised shift register with synchronous clear
module cordic_delay_line
  import cordic_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = ADD_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift one tap per cycle; reset clears every tap so in-flight entries vanish
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/cordic_rot_stage.sv
// rtl/cordic_rot_stage.sv - one pipelined CORDIC micro-rotation for iteration SHIFT
module cordic_rot_stage
  import cordic_pkg::*;
#(
  parameter int                  SHIFT = 0,
  parameter logic [CORDIC_W-1:0] ATAN  = 16'h2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic                mode_in,
  input  logic [CORDIC_W-1:0] x_in,
  input  logic [CORDIC_W-1:0] y_in,
  input  logic [CORDIC_W-1:0] z_in,
  output logic                valid_out,
  output logic                mode_out,
  output logic [CORDIC_W-1:0] x_out,
  output logic [CORDIC_W-1:0] y_out,
  output logic [CORDIC_W-1:0] z_out
);

  logic                dir;
  logic [CORDIC_W-1:0] xs;
  logic [CORDIC_W-1:0] ys;
  logic [CORDIC_W-1:0] x_sum;
  logic [CORDIC_W-1:0] y_sum;
  logic [CORDIC_W-1:0] z_sum;
  logic [1:0]          align_q;
  logic                valid_d;
  logic                mode_d;

  // Direction: rotation drives z toward zero, vectoring drives y toward zero
  always_comb begin
    dir = 1'b0;
    if (mode_in == MODE_VEC) begin
      dir = y_in[CORDIC_W-1];
    end else begin
      dir = ~z_in[CORDIC_W-1];
    end
  end

  assign xs = CORDIC_W'($signed(x_in) >>> SHIFT);
  assign ys = CORDIC_W'($signed(y_in) >>> SHIFT);

  // dir=1: x-ys, y+xs, z-ATAN; dir=0: x+ys, y-xs, z+ATAN
  adder_pipe u_add_x (
    .clk  (clk),
    .a1   (x_in),
    .a2   (ys),
    .sign (dir),
    .sum  (x_sum)
  );

  adder_pipe u_add_y (
    .clk  (clk),
    .a1   (y_in),
    .a2   (xs),
    .sign (~dir),
    .sum  (y_sum)
  );

  adder_pipe u_add_z (
    .clk  (clk),
    .a1   (z_in),
    .a2   (ATAN),
    .sign (dir),
    .sum  (z_sum)
  );

  // Valid and mode travel beside the adders so they arrive with their own sums
  cordic_delay_line #(
    .WIDTH (2),
    .DEPTH (ADD_LAT)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .d     ({mode_in, valid_in}),
    .q     (align_q)
  );

  assign valid_d = align_q[0];
  assign mode_d  = align_q[1];

  // Output register: capture a finished sample, otherwise hold the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      mode_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      valid_out <= valid_d;
      if (valid_d) begin
        mode_out <= mode_d;
        x_out    <= x_sum;
        y_out    <= y_sum;
        z_out    <= z_sum;
      end
    end
  end

endmodule

// File: tb/tb_cordic_rot_stage.sv
// tb/tb_cordic_rot_stage.sv - self-checking bench for cordic_rot_stage at SHIFT=0 and SHIFT=2
module tb_cordic_rot_stage;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        mode_in = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic [15:0] z_in = '0;

  logic        v_o [2];
  logic        m_o [2];
  logic [15:0] x_o [2];
  logic [15:0] y_o [2];
  logic [15:0] z_o [2];

  typedef struct {
    logic        rst;
    logic        v;
    logic        m;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } stim_t;

  stim_t       hist [$];
  logic [15:0] ex [2];
  logic [15:0] ey [2];
  logic [15:0] ez [2];
  logic        em [2];
  int          shifts [2] = '{0, 2};
  int          atans  [2] = '{32'h2000, 32'h09FB};

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cordic_rot_stage #(.SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mode_in(mode_in),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .valid_out(v_o[0]), .mode_out(m_o[0]), .x_out(x_o[0]), .y_out(y_o[0]), .z_out(z_o[0])
  );

  cordic_rot_stage #(.SHIFT(2), .ATAN(atan_lut(2))) dut2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mode_in(mode_in),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .valid_out(v_o[1]), .mode_out(m_o[1]), .x_out(x_o[1]), .y_out(y_o[1]), .z_out(z_o[1])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int p);
    int q;
    q = a / p;
    if ((a % p != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference micro-rotation in plain integer arithmetic, wrapped to 16 bits
  function automatic void rot_ref(input int shift, input int atan, input logic m,
                                  input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                  output logic [15:0] rx, output logic [15:0] ry, output logic [15:0] rz);
    int sx, sy, sz, sigma, p, nx, ny, nz;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sz = int'($signed(z));
    p  = 1 << shift;
    if (m) sigma = (sy < 0) ? 1 : -1;
    else   sigma = (sz >= 0) ? 1 : -1;
    nx = sx - sigma * floor_div(sy, p);
    ny = sy + sigma * floor_div(sx, p);
    nz = sz - sigma * atan;
    rx = nx[15:0];
    ry = ny[15:0];
    rz = nz[15:0];
  endfunction

  // Expected state after the most recent edge: a sample emerges 6 cycles on unless a reset hit it
  task automatic check_outputs();
    int   e;
    int   src;
    logic live;
    e   = hist.size() - 1;
    src = e - 5;
    live = 1'b0;
    if (hist[e].rst) begin
      for (int k = 0; k < 2; k++) begin
        ex[k] = '0; ey[k] = '0; ez[k] = '0; em[k] = 1'b0;
      end
    end else begin
      if (src >= 0) begin
        live = hist[src].v && !hist[src].rst;
        for (int j = src + 1; j <= e; j++) begin
          if (hist[j].rst) live = 1'b0;
        end
      end
      if (live) begin
        for (int k = 0; k < 2; k++) begin
          rot_ref(shifts[k], atans[k], hist[src].m, hist[src].x, hist[src].y, hist[src].z,
                  ex[k], ey[k], ez[k]);
          em[k] = hist[src].m;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("s%0d_valid_e%0d", shifts[k], e), {15'b0, v_o[k]}, {15'b0, live});
      chk($sformatf("s%0d_mode_e%0d", shifts[k], e), {15'b0, m_o[k]}, {15'b0, em[k]});
      chk($sformatf("s%0d_x_e%0d", shifts[k], e), x_o[k], ex[k]);
      chk($sformatf("s%0d_y_e%0d", shifts[k], e), y_o[k], ey[k]);
      chk($sformatf("s%0d_z_e%0d", shifts[k], e), z_o[k], ez[k]);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic m,
                      input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    stim_t s;
    reset = r; valid_in = v; mode_in = m; x_in = x; y_in = y; z_in = z;
    @(posedge clk);
    s.rst = r; s.v = v; s.m = m; s.x = x; s.y = y; s.z = z;
    hist.push_back(s);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    // Reset with junk on the inputs
    repeat (3) step(1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    chk("rst_valid", {15'b0, v_o[0]}, 16'h0000);
    chk("rst_x", x_o[0], 16'h0000);
    chk("rst_z2", z_o[1], 16'h0000);
    chk("rst_mode2", {15'b0, m_o[1]}, 16'h0000);

    // Rotation, SHIFT=0
    step(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1000);
    repeat (5) idle();
    chk("t1_valid", {15'b0, v_o[0]}, 16'h0001);
    chk("t1_x", x_o[0], 16'h4000);
    chk("t1_y", y_o[0], 16'h4000);
    chk("t1_z", z_o[0], 16'hF000);
    idle();
    chk("t1_pulse", {15'b0, v_o[0]}, 16'h0000);
    chk("t1_hold_x", x_o[0], 16'h4000);

    // Vectoring, SHIFT=0
    step(1'b0, 1'b1, 1'b1, 16'h3000, 16'h1000, 16'h0000);
    repeat (5) idle();
    chk("t2_x", x_o[0], 16'h4000);
    chk("t2_y", y_o[0], 16'hE000);
    chk("t2_z", z_o[0], 16'h2000);
    chk("t2_mode", {15'b0, m_o[0]}, 16'h0001);

    // Rotation with negative angle, SHIFT=2
    step(1'b0, 1'b1, 1'b0, 16'h4000, 16'hC000, 16'hFFFF);
    repeat (5) idle();
    chk("t3_x", x_o[1], 16'h3000);
    chk("t3_y", y_o[1], 16'hB000);
    chk("t3_z", z_o[1], 16'h09FA);

    // Wrap-around, SHIFT=0
    step(1'b0, 1'b1, 1'b1, 16'h7000, 16'h2000, 16'h0000);
    repeat (5) idle();
    chk("t4_x", x_o[0], 16'h9000);
    chk("t4_y", y_o[0], 16'hB000);
    chk("t4_z", z_o[0], 16'h2000);

    // Random stream with gaps and mixed mode
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    repeat (6) idle();

    // Reset pulse with three samples in flight
    repeat (3) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
    step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 16'h9ABC);
    chk("t6_rst_valid", {15'b0, v_o[0]}, 16'h0000);
    chk("t6_rst_x", x_o[0], 16'h0000);
    chk("t6_rst_y", y_o[1], 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1000);
    repeat (4) begin
      idle();
      chk("t6_no_stale", {15'b0, v_o[0]}, 16'h0000);
    end
    idle();
    chk("t6_valid", {15'b0, v_o[0]}, 16'h0001);
    chk("t6_x", x_o[0], 16'h4000);
    chk("t6_y", y_o[0], 16'h4000);
    chk("t6_z", z_o[0], 16'hF000);
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
